// File: rtl/div_pkg.sv
// Shared defaults, result record and small helpers for the divider result collector.
package div_pkg;

   localparam int unsigned DIV_DATA_W = 10;
   localparam int unsigned DIV_DEPTH  = 4;

   typedef struct packed {
      logic [DIV_DATA_W-1:0] q;
      logic                  ovf;
      logic                  dvz;
   } div_result_t;

   function automatic logic is_err(input logic ovf, input logic dvz);
      return ovf | dvz;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/div_result_fifo.sv
// First-word-fall-through result FIFO; full/empty come from the entry count, not pointer equality.
module div_result_fifo
   import div_pkg::*;
#(
   parameter int unsigned W     = DIV_DATA_W + 2,
   parameter int unsigned DEPTH = DIV_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclr,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic                       rvalid,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     mem_q [DEPTH];

   logic push_ok;
   logic pop_ok;

   assign rvalid  = (cnt_q != '0);
   assign full    = (cnt_q == FULL_CNT);
   assign count   = cnt_q;
   assign pop_ok  = pop & rvalid;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = rvalid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (sclr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !sclr) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/div_result_collector.sv
// Captures divider results on the rising edge of div_valid into a FWFT FIFO, flags drops.
// Optional statistics counters (err_cnt, drop_cnt) are enabled with DIV_COLLECT_STATS_EN.
module div_result_collector
   import div_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_DATA_W,
   parameter int unsigned DEPTH  = DIV_DEPTH
) (
`ifdef DIV_COLLECT_STATS_EN
   output logic [7:0]                 err_cnt,
   output logic [7:0]                 drop_cnt,
`endif
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclr,
   input  logic                       div_valid,
   input  logic [DATA_W-1:0]          div_q,
   input  logic                       div_ovf,
   input  logic                       div_dvz,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_q,
   output logic                       out_ovf,
   output logic                       out_dvz,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       drop
);

   localparam int unsigned ENTRY_W = DATA_W + 2;

   // armed_q means div_valid was seen low last cycle; cleared by reset so a
   // level already high at release waits for a low before it can capture.
   logic armed_q, armed_d;
   logic drop_q, drop_d;

   logic               capture;
   logic               pop;
   logic               accepted;
   logic [ENTRY_W-1:0] wdata;
   logic [ENTRY_W-1:0] rdata;

   assign capture  = div_valid & armed_q;
   assign pop      = out_valid & out_ready;
   assign accepted = capture & (~full | pop);
   assign wdata    = {div_q, div_ovf, div_dvz};

   div_result_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .sclr   (sclr),
      .push   (capture),
      .wdata  (wdata),
      .pop    (pop),
      .rdata  (rdata),
      .rvalid (out_valid),
      .full   (full),
      .count  (count)
   );

   assign out_q   = rdata[ENTRY_W-1:2];
   assign out_ovf = rdata[1];
   assign out_dvz = rdata[0];
   assign drop    = drop_q;

   always_comb begin
      armed_d = ~div_valid;
      drop_d  = capture & full & ~pop;
      if (sclr) begin
         armed_d = 1'b0;
         drop_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         armed_q <= armed_d;
         drop_q  <= drop_d;
      end
   end

`ifdef DIV_COLLECT_STATS_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      err_cnt_d  = err_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (sclr) begin
         err_cnt_d  = '0;
         drop_cnt_d = '0;
      end else begin
         if (accepted && is_err(div_ovf, div_dvz)) err_cnt_d = sat_inc8(err_cnt_q);
         if (drop_d) drop_cnt_d = sat_inc8(drop_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         err_cnt_q  <= err_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign err_cnt  = err_cnt_q;
   assign drop_cnt = drop_cnt_q;
`else
   logic unused_accepted;
   assign unused_accepted = accepted;
`endif

endmodule
